// File: rtl/wb_arb5_module.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb5_module
//  Description : Round-robin writeback arbiter for five result producers with
//                a single registered output stage and mux5 select code.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb5_module #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              src_valid,
  output logic [4:0]              src_ready,
  input  logic [5*DATA_WIDTH-1:0] src_data,
  input  logic [5*TAG_WIDTH-1:0]  src_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]    out_rd,
  output logic [2:0]              out_src,
  output logic [3:0]              mux5_sel
);

  localparam int c_NUM_SRC = 5;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [TAG_WIDTH-1:0]  r_out_rd;
  logic [2:0]            r_out_src;
  logic [3:0]            r_mux5_sel;
  logic [2:0]            r_rr_ptr;

  logic       w_grant_any;
  logic [2:0] w_grant_idx;
  logic [2:0] w_scan;
  logic       w_can_load;
  logic       w_load;

  // Modulo-5 add of two indices, each already in 0..4.
  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  function automatic logic [3:0] sel_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0010;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // First valid source at or after rr_ptr, wrapping 4 -> 0.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < c_NUM_SRC; k++) begin
      w_scan = wrap_add(r_rr_ptr, 3'(k));
      if (!w_grant_any && src_valid[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  assign w_can_load = ~r_out_valid | out_ready;
  assign w_load     = w_grant_any & w_can_load & ~rst;
  assign src_ready  = w_load ? (5'd1 << w_grant_idx) : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_src   <= '0;
      r_mux5_sel  <= 4'b0000;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= src_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      r_out_rd    <= src_rd[w_grant_idx*TAG_WIDTH +: TAG_WIDTH];
      r_out_src   <= w_grant_idx;
      r_mux5_sel  <= sel_code(w_grant_idx);
      r_rr_ptr    <= wrap_add(w_grant_idx, 3'd1);
    end else if (out_ready) begin
      // Drain with nothing new to load: payload fields keep their last values.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;
  assign out_src   = r_out_src;
  assign mux5_sel  = r_mux5_sel;

endmodule
`default_nettype wire
